// File: rtl/fault_inj_pkg.sv
// Shared types and constants for the ECC-demo fault injector.
package fault_inj_pkg;

    typedef enum logic [1:0] {PASS, STICKY, ONESHOT, RANDOM} inj_mode_t;

    // Galois taps for x^8+x^6+x^5+x^4+1 in a right-shifting register.
    localparam logic [7:0] LFSR_POLY = 8'hB8;

    // Width needed to hold a Hamming position 0..n.
    function automatic int pos_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/fault_injector_btn_conditioner.sv
// Button conditioner: 2-FF synchroniser, debounce counter, single press pulse.
module btn_conditioner #(
    parameter int DEBOUNCE = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE + 1);

    logic [1:0]    sync;
    logic          level;
    logic [CW-1:0] cnt;

    // The level is only replaced after DEBOUNCE consecutive differing samples;
    // any return to the old level restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= '0;
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync  <= {sync[0], btn};
            press <= 1'b0;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE - 1)) begin
                level <= sync[1];
                cnt   <= '0;
                press <= sync[1];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fault_injector_ctrl.sv
// Fault injector between Hamming encoder and decoder: button-edited mask, four
// injection modes, 1-cycle registered output with ready/valid handshake.
module fault_injector_ctrl
    import fault_inj_pkg::*;
#(
    parameter int         N         = 7,
    parameter int         DEBOUNCE  = 16,
    parameter logic [7:0] LFSR_SEED = 8'hA5,
    parameter int         CNT_W     = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N:1]          code_in,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          mode,
    input  logic [3:0]          BTN,
    output logic [N:1]          noisy_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [N:1]          fault_mask,
    output logic [pos_w(N)-1:0] cursor,
    output logic [N:1]          err_mask,
    output logic                armed,
    output logic [CNT_W-1:0]    fault_cnt
);
    localparam int PW = pos_w(N);

    logic [3:0] press;
    inj_mode_t  md;
    logic [7:0] lfsr;
    logic [N:1] m;
    logic [N:1] cur_bit;
    logic       accept;

    btn_conditioner #(.DEBOUNCE(DEBOUNCE)) u_btn [3:0] (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (BTN),
        .press (press)
    );

    assign md       = inj_mode_t'(mode);
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        m       = '0;
        cur_bit = '0;
        for (int i = 1; i <= N; i++) cur_bit[i] = (cursor == PW'(i));
        case (md)
            STICKY:  m = err_mask;
            ONESHOT: if (armed) m = err_mask;
            RANDOM:  for (int i = 1; i <= N; i++) m[i] = (lfsr[PW-1:0] == PW'(i));
            default: m = '0;
        endcase
    end

    // Mask editing; clear overrides a same-cycle toggle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cursor   <= PW'(1);
            err_mask <= '0;
            armed    <= 1'b0;
        end else begin
            if (press[0]) cursor <= (cursor == PW'(N)) ? PW'(1) : cursor + 1'b1;
            if (press[2])      err_mask <= '0;
            else if (press[1]) err_mask <= err_mask ^ cur_bit;
            if (md != ONESHOT)       armed <= 1'b0;
            else if (accept && armed) armed <= 1'b0;
            else if (press[3])        armed <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            noisy_data <= '0;
            fault_mask <= '0;
            out_valid  <= 1'b0;
            lfsr       <= LFSR_SEED;
            fault_cnt  <= '0;
        end else begin
            if (accept) begin
                noisy_data <= code_in ^ m;
                fault_mask <= m;
                out_valid  <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept && md == RANDOM)
                lfsr <= {1'b0, lfsr[7:1]} ^ (lfsr[0] ? LFSR_POLY : 8'h00);
            if (accept && |m && fault_cnt != '1)
                fault_cnt <= fault_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_fault_injector_ctrl.sv
// Self-checking bench for fault_injector_ctrl: table vectors, button corner
// sequences and randomized words against an abstract reference model.
module tb_fault_injector_ctrl;
    import fault_inj_pkg::*;

    localparam int N  = 7;
    localparam int DB = 4;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N:1]    code_in;
    logic          in_valid, in_ready;
    logic [1:0]    mode;
    logic [3:0]    BTN;
    logic [N:1]    noisy_data, fault_mask, err_mask;
    logic          out_valid, out_ready;
    logic [2:0]    cursor;
    logic          armed;
    logic [CW-1:0] fault_cnt;

    fault_injector_ctrl #(.N(N), .DEBOUNCE(DB), .LFSR_SEED(8'hA5), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .code_in(code_in), .in_valid(in_valid),
        .in_ready(in_ready), .mode(mode), .BTN(BTN), .noisy_data(noisy_data),
        .out_valid(out_valid), .out_ready(out_ready), .fault_mask(fault_mask),
        .cursor(cursor), .err_mask(err_mask), .armed(armed), .fault_cnt(fault_cnt)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;

    // Reference model state
    int         cur_m;
    logic [N:1] mask_m;
    bit         armed_m;
    logic [7:0] lfsr_m;
    int         cnt_m;
    logic [1:0] mode_m;

    typedef struct {
        logic [1:0] md;
        logic [N:1] code;
        logic [N:1] en;
        logic [N:1] em;
    } vec_t;
    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        cur_m = 1; mask_m = '0; armed_m = 0; lfsr_m = 8'hA5; cnt_m = 0;
    endtask

    function automatic logic [N:1] model_m();
        int p;
        case (mode_m)
            2'd0: return '0;
            2'd1: return mask_m;
            2'd2: return armed_m ? mask_m : '0;
            default: begin
                p = int'(lfsr_m % 8);
                if (p >= 1 && p <= N) return N'(1) << (p - 1);
                return '0;
            end
        endcase
    endfunction

    task automatic chk_state(input string tag);
        chk({tag, ".cursor"}, 32'(cursor), 32'(cur_m));
        chk({tag, ".err_mask"}, 32'(err_mask), 32'(mask_m));
        chk({tag, ".armed"}, 32'(armed), 32'(armed_m));
        chk({tag, ".fault_cnt"}, 32'(fault_cnt), 32'(cnt_m));
    endtask

    task automatic set_mode(input logic [1:0] md);
        mode = md; mode_m = md;
        if (md != 2'd2) armed_m = 0;
        @(negedge clk);
    endtask

    // Hold buttons long enough to pass sync + debounce, then release fully.
    task automatic press(input logic [3:0] b);
        int old;
        BTN = b;
        repeat (DB + 6) @(negedge clk);
        BTN = '0;
        repeat (DB + 6) @(negedge clk);
        old = cur_m;
        if (b[0]) cur_m = (cur_m == N) ? 1 : cur_m + 1;
        if (b[2]) mask_m = '0;
        else if (b[1]) mask_m = mask_m ^ (N'(1) << (old - 1));
        if (b[3] && mode_m == 2'd2 && !armed_m) armed_m = 1;
    endtask

    // Present one word (accepted at the next posedge since out_ready is high
    // or out_valid is low), then check the registered result.
    task automatic send_exp(input logic [N:1] c, input logic [N:1] en, input logic [N:1] em,
                            input string tag);
        logic [N:1] mm;
        mm = model_m();
        code_in = c; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, ".noisy"}, 32'(noisy_data), 32'(en));
        chk({tag, ".fmask"}, 32'(fault_mask), 32'(em));
        chk({tag, ".ovalid"}, 32'(out_valid), 32'd1);
        if (mm != 0 && cnt_m < 65535) cnt_m++;
        if (mode_m == 2'd2) armed_m = 0;
        if (mode_m == 2'd3) begin
            if (lfsr_m[0]) lfsr_m = (lfsr_m >> 1) ^ 8'hB8;
            else           lfsr_m = lfsr_m >> 1;
        end
    endtask

    task automatic send(input logic [N:1] c, input string tag);
        logic [N:1] mm;
        mm = model_m();
        send_exp(c, c ^ mm, mm, tag);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N:1] hold_n, hold_m, w;
        rst_n = 1'b0; code_in = '0; in_valid = 1'b0; mode = 2'd0; mode_m = 2'd0;
        BTN = '0; out_ready = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst.noisy", 32'(noisy_data), 32'd0);
        chk("rst.fmask", 32'(fault_mask), 32'd0);
        chk("rst.ovalid", 32'(out_valid), 32'd0);
        chk("rst.iready", 32'(in_ready), 32'd1);
        chk_state("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // Test 1: sticky with empty mask is transparent
        set_mode(2'd1);
        send_exp(7'b1011010, 7'b1011010, 7'b0000000, "t1");
        chk("t1.cnt", 32'(fault_cnt), 32'd0);

        // Arm outside ONESHOT must not stick
        press(4'b1000);
        chk_state("arm_sticky");

        // Test 2: cursor 1->3, toggle bit 3
        press(4'b0001); press(4'b0001);
        chk("t2.cursor", 32'(cursor), 32'd3);
        press(4'b0010);
        chk("t2.mask", 32'(err_mask), 32'(7'b0000100));
        tbl[0] = '{2'd1, 7'b0000000, 7'b0000100, 7'b0000100};
        tbl[1] = '{2'd1, 7'b0000000, 7'b0000100, 7'b0000100};
        tbl[2] = '{2'd0, 7'b1111111, 7'b1111111, 7'b0000000};
        tbl[3] = '{2'd1, 7'b1111111, 7'b1111011, 7'b0000100};
        tbl[4] = '{2'd1, 7'b1011010, 7'b1011110, 7'b0000100};
        tbl[5] = '{2'd0, 7'b1011010, 7'b1011010, 7'b0000000};
        for (int i = 0; i < 6; i++) begin
            set_mode(tbl[i].md);
            send_exp(tbl[i].code, tbl[i].en, tbl[i].em, $sformatf("tbl%0d", i));
            if (i == 1) chk("t2.cnt", 32'(fault_cnt), 32'd2);
        end
        chk_state("tbl");

        // Clear + toggle + advance together: clear wins, advance applies
        press(4'b0111);
        chk("clr.mask", 32'(err_mask), 32'd0);
        chk("clr.cursor", 32'(cursor), 32'd4);
        press(4'b0001); press(4'b0001); press(4'b0001);
        press(4'b0010);
        press(4'b0001);
        chk("wrap.cursor", 32'(cursor), 32'd1);
        press(4'b0010);
        chk("t3.mask", 32'(err_mask), 32'(7'b1000001));

        // Test 3: one-shot
        set_mode(2'd2);
        press(4'b1000);
        chk("t3.armed", 32'(armed), 32'd1);
        press(4'b1000);
        chk("t3.rearm", 32'(armed), 32'd1);
        send_exp(7'h00, 7'b1000001, 7'b1000001, "t3a");
        chk("t3.disarm", 32'(armed), 32'd0);
        send_exp(7'h00, 7'h00, 7'h00, "t3b");
        send_exp(7'h00, 7'h00, 7'h00, "t3c");
        chk_state("t3");

        // Test 4: bounce shorter than DEBOUNCE, then a clean hold
        for (int i = 0; i < 8; i++) begin
            BTN[0] = 1'b1; repeat (2) @(negedge clk);
            BTN[0] = 1'b0; repeat (2) @(negedge clk);
        end
        chk("t4.bounce", 32'(cursor), 32'd1);
        BTN[0] = 1'b1; repeat (DB + 4) @(negedge clk);
        BTN[0] = 1'b0; repeat (DB + 6) @(negedge clk);
        chk("t4.one", 32'(cursor), 32'd2);
        cur_m = 2;
        for (int i = 0; i < 6; i++) press(4'b0001);
        chk("t4.seven", 32'(cursor), 32'd1);

        // Test 5: RANDOM mode from the LFSR
        set_mode(2'd3);
        for (int i = 0; i < 20; i++) begin
            send(N'($urandom), $sformatf("rnd%0d", i));
            chk("rnd.pop", 32'($countones(fault_mask) <= 1), 32'd1);
        end
        chk("rnd.cnt", 32'(fault_cnt), 32'(cnt_m));

        // Mixed random modes and button activity
        for (int i = 0; i < 30; i++) begin
            set_mode(2'($urandom_range(0, 3)));
            if ($urandom_range(0, 3) == 0) press(4'($urandom_range(0, 15)));
            send(N'($urandom), $sformatf("mix%0d", i));
        end
        chk_state("mix");

        // Test 6: stall, then reset mid-stall
        if (cur_m == 1) press(4'b0001);
        if (mask_m == 0) press(4'b0010);
        set_mode(2'd1);
        out_ready = 1'b0;
        send(7'b0110011, "t6a");
        hold_n = noisy_data; hold_m = fault_mask;
        code_in = 7'b1111000; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t6.iready", 32'(in_ready), 32'd0);
            chk("t6.hold_n", 32'(noisy_data), 32'(hold_n));
            chk("t6.hold_m", 32'(fault_mask), 32'(hold_m));
        end
        out_ready = 1'b1;
        #1 chk("t6.iready_up", 32'(in_ready), 32'd1);
        send(7'b1111000, "t6b");
        @(negedge clk);
        chk("t6.drain", 32'(out_valid), 32'd0);
        out_ready = 1'b0;
        w = N'($urandom);
        send(w, "t6c");
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6.rst_ov", 32'(out_valid), 32'd0);
        chk("t6.rst_mask", 32'(err_mask), 32'd0);
        chk("t6.rst_cur", 32'(cursor), 32'd1);
        chk("t6.rst_fm", 32'(fault_mask), 32'd0);
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        model_reset();
        chk_state("t6.post");
        set_mode(2'd3);
        send_exp(7'b0000000, 7'b0010000, 7'b0010000, "seed");

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
